dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache controller for the MEM stage of the five-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It serves CPU loads and stores from an internal line store and fills or evicts 256-bit lines over a request/acknowledge handshake to off-chip data memory. Its `stall_o` output freezes every pipeline register, including MEM/WB, while a miss is outstanding.

---
 rtl/dcache_pkg.sv | 18 +
 rtl/dcache_sram.sv | 57 +++++
 rtl/dcache_ctrl.sv | 147 ++++++++++++++
 tb/tb_dcache_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-field constants for the MEM-stage data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned WORD_W       = 32;
    localparam int unsigned LINE_W       = 256;
    localparam int unsigned WORD_SEL_W   = 3;
    localparam int unsigned WORD_SEL_LSB = 2;
    localparam int unsigned OFFSET_W     = 5;
    localparam int unsigned INDEX_LSB    = 5;

endpackage

// File: rtl/dcache_sram.sv
// Line store: per-line valid/dirty/tag/data with async read and one sync write port.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int unsigned LINES = 32,
    parameter int unsigned TAG_W = 22,
    parameter int unsigned IDX_W = $clog2(LINES)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_W-1:0]      idx,
    output logic                  valid,
    output logic                  dirty,
    output logic [TAG_W-1:0]      tag,
    output logic [LINE_W-1:0]     line,
    input  logic                  line_we,
    input  logic [TAG_W-1:0]      line_tag,
    input  logic [LINE_W-1:0]     line_data,
    input  logic                  word_we,
    input  logic [WORD_SEL_W-1:0] word_sel,
    input  logic [WORD_W-1:0]     word_data
);

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    assign valid = valid_q[idx];
    assign dirty = dirty_q[idx];
    assign tag   = tag_q[idx];
    assign line  = data_q[idx];

    // Status bits: cleared by reset, set clean on refill, marked dirty on word merge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data arrays: whole-line refill or single-word store merge, no reset.
    always_ff @(posedge clk_i) begin
        if (line_we) begin
            tag_q[idx]  <= line_tag;
            data_q[idx] <= line_data;
        end else if (word_we) begin
            data_q[idx][word_sel*WORD_W +: WORD_W] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache controller for the MEM stage.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned LINES = 32,
    parameter int unsigned TAG_W = 22
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        data_i,
    input  logic               MemRead_i,
    input  logic               MemWrite_i,
    output logic [31:0]        data_o,
    output logic               stall_o,
    output logic [31:0]        mem_addr_o,
    output logic [LINE_W-1:0]  mem_data_o,
    output logic               mem_enable_o,
    output logic               mem_write_o,
    input  logic [LINE_W-1:0]  mem_data_i,
    input  logic               mem_ack_i
);

    localparam int unsigned IDX_W = $clog2(LINES);

    state_t                state_q, state_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]     mem_data_q, mem_data_d;

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic [WORD_SEL_W-1:0] word_sel;
    logic                  rd_valid, rd_dirty;
    logic [TAG_W-1:0]      rd_tag;
    logic [LINE_W-1:0]     rd_line;
    logic                  active, load, hit, miss_idle;
    logic                  line_we, word_we;
    // Byte offset within a word is architecturally ignored.
    logic                  unused_byte_off;

    assign idx             = addr_i[INDEX_LSB +: IDX_W];
    assign tag             = addr_i[ADDR_W-1 -: TAG_W];
    assign word_sel        = addr_i[WORD_SEL_LSB +: WORD_SEL_W];
    assign unused_byte_off = ^addr_i[1:0];

    assign active    = MemRead_i | MemWrite_i;
    assign load      = MemRead_i & ~MemWrite_i;
    assign hit       = rd_valid && (rd_tag == tag);
    assign miss_idle = (state_q == IDLE) && active && !hit;
    assign word_we   = (state_q == IDLE) && MemWrite_i && hit;
    assign line_we   = (state_q == ALLOCATE) && mem_ack_i;

    // CPU-facing outputs are gated by reset so they read zero while it is asserted.
    assign stall_o = rst_i && ((state_q != IDLE) || miss_idle);
    assign data_o  = (rst_i && (state_q == IDLE) && load && hit)
                     ? rd_line[word_sel*WORD_W +: WORD_W] : '0;

    assign mem_enable_o = mem_en_q;
    assign mem_write_o  = mem_wr_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    dcache_sram #(
        .LINES (LINES),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_sram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .idx       (idx),
        .valid     (rd_valid),
        .dirty     (rd_dirty),
        .tag       (rd_tag),
        .line      (rd_line),
        .line_we   (line_we),
        .line_tag  (tag),
        .line_data (mem_data_i),
        .word_we   (word_we),
        .word_sel  (word_sel),
        .word_data (data_i)
    );

    // FSM state and memory-port request registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_en_q   <= mem_en_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    // Next state and next memory request; request fields are loaded on entry to each phase.
    always_comb begin
        state_d    = state_q;
        mem_en_d   = mem_en_q;
        mem_wr_d   = mem_wr_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        case (state_q)
            IDLE: begin
                if (miss_idle) begin
                    mem_en_d = 1'b1;
                    if (rd_valid && rd_dirty) begin
                        state_d    = WRITEBACK;
                        mem_wr_d   = 1'b1;
                        mem_addr_d = {rd_tag, idx, {OFFSET_W{1'b0}}};
                        mem_data_d = rd_line;
                    end else begin
                        state_d    = ALLOCATE;
                        mem_wr_d   = 1'b0;
                        mem_addr_d = {tag, idx, {OFFSET_W{1'b0}}};
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d    = ALLOCATE;
                    mem_wr_d   = 1'b0;
                    mem_addr_d = {tag, idx, {OFFSET_W{1'b0}}};
                end
            end
            ALLOCATE: begin
                if (mem_ack_i) begin
                    state_d  = IDLE;
                    mem_en_d = 1'b0;
                    mem_wr_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus randomized accesses
// checked every cycle against a transaction-level cache and memory model.
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [31:0]  addr_i;
    logic [31:0]  data_i;
    logic         MemRead_i;
    logic         MemWrite_i;
    logic [31:0]  data_o;
    logic         stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    always #5 clk = ~clk;

    dcache_ctrl #(
        .LINES (32),
        .TAG_W (22)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .addr_i       (addr_i),
        .data_i       (data_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .data_o       (data_o),
        .stall_o      (stall_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    int tests = 0;
    int fails = 0;

    // Cache model: one entry per line.
    bit           mv [32];
    bit           md [32];
    logic [21:0]  mt [32];
    logic [255:0] ml [32];
    // Backing memory model keyed by line address.
    logic [255:0] mem [int unsigned];

    // Observations from the most recent access.
    logic         first_stall;
    logic [31:0]  last_data;
    logic [31:0]  last_wb_addr;
    logic [255:0] last_wb_data;
    logic [31:0]  last_fetch_addr;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] pattern(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = (la * 32'h9E3779B1) ^ (32'h01010101 * (w + 1));
        return l;
    endfunction

    function automatic logic [255:0] get_line(input logic [31:0] la);
        if (mem.exists(la)) return mem[la];
        return pattern(la);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
    endtask

    // Memory side: hold the request for k cycles, pulsing ack in the k-th, checking every cycle.
    task automatic mem_phase(input bit is_wb, input logic [31:0] exp_addr, input logic [255:0] exp_data);
        int unsigned k;
        k = $urandom_range(1, 4);
        for (int c = 1; c <= int'(k); c++) begin
            mem_ack_i = (c == int'(k));
            @(negedge clk);
            chk("req_stall", stall_o, 1'b1);
            chk("req_en", mem_enable_o, 1'b1);
            chk("req_wr", mem_write_o, is_wb);
            chk("req_addr", mem_addr_o, exp_addr);
            if (is_wb) begin
                chk("wb_data", mem_data_o, exp_data);
                last_wb_addr = mem_addr_o;
                last_wb_data = mem_data_o;
            end else begin
                last_fetch_addr = mem_addr_o;
            end
            @(posedge clk);
            #1;
            mem_ack_i = 1'b0;
        end
    endtask

    // One CPU access run to completion; called at posedge+1.
    task automatic do_access(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] wd);
        int unsigned idx;
        int unsigned w;
        logic [21:0] tg;
        logic [31:0] vaddr, faddr;
        bit          hit;
        idx = a[9:5];
        w   = a[4:2];
        tg  = a[31:10];
        hit = mv[idx] && (mt[idx] == tg);
        addr_i     = a;
        data_i     = wd;
        MemRead_i  = rd;
        MemWrite_i = wr;
        if (!hit) begin
            @(negedge clk);
            first_stall = stall_o;
            chk("miss_stall", stall_o, 1'b1);
            chk("miss_idle_en", mem_enable_o, 1'b0);
            @(posedge clk);
            #1;
            if (mv[idx] && md[idx]) begin
                vaddr = {mt[idx], a[9:5], 5'b0};
                mem_phase(1'b1, vaddr, ml[idx]);
                mem[vaddr] = ml[idx];
                md[idx] = 1'b0;
            end
            faddr = {tg, a[9:5], 5'b0};
            mem_data_i = get_line(faddr);
            mem_phase(1'b0, faddr, '0);
            mv[idx] = 1'b1;
            md[idx] = 1'b0;
            mt[idx] = tg;
            ml[idx] = get_line(faddr);
            mem_data_i = {8{$urandom()}};
        end
        @(negedge clk);
        if (hit) first_stall = stall_o;
        chk("hit_stall", stall_o, 1'b0);
        chk("hit_en", mem_enable_o, 1'b0);
        if (rd && !wr) chk("load_data", data_o, ml[idx][w*32 +: 32]);
        last_data = data_o;
        @(posedge clk);
        #1;
        if (wr) begin
            ml[idx][w*32 +: 32] = wd;
            md[idx] = 1'b1;
        end
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
    endtask

    // A cycle with no request; optionally a spurious ack from memory.
    task automatic idle_cycle(input bit spurious_ack);
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        addr_i     = $urandom();
        mem_ack_i  = spurious_ack;
        @(negedge clk);
        chk("idle_stall", stall_o, 1'b0);
        chk("idle_en", mem_enable_o, 1'b0);
        chk("idle_data", data_o, 32'h0);
        @(posedge clk);
        #1;
        mem_ack_i = 1'b0;
    endtask

    initial begin
        logic [255:0] l40;
        logic [31:0]  ra;
        int unsigned  op;
        int unsigned  tsel;

        rst_i      = 1'b0;
        addr_i     = 32'h40;
        data_i     = '0;
        MemRead_i  = 1'b1;
        MemWrite_i = 1'b0;
        mem_data_i = '0;
        mem_ack_i  = 1'b0;
        model_reset();

        // Reset state, with a read request present to show outputs are held low.
        #8;
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_data", data_o, 32'h0);
        chk("rst_en", mem_enable_o, 1'b0);
        chk("rst_wr", mem_write_o, 1'b0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_mdata", mem_data_o, 256'h0);
        MemRead_i = 1'b0;
        #4;
        rst_i = 1'b1;
        @(posedge clk);
        #1;

        // Clean miss at 0x40, word2 of the fetched line is DEADBEEF.
        l40 = pattern(32'h40);
        l40[95:64] = 32'hDEADBEEF;
        mem[32'h40] = l40;
        do_access(32'h40, 1'b1, 1'b0, '0);
        chk("t1_fetch_addr", last_fetch_addr, 32'h40);
        chk("t1_first_stall", first_stall, 1'b1);
        do_access(32'h48, 1'b1, 1'b0, '0);
        chk("t1_word2", last_data, 32'hDEADBEEF);
        chk("t1_hit_nostall", first_stall, 1'b0);

        // Store hit then read back.
        do_access(32'h48, 1'b0, 1'b1, 32'h12345678);
        chk("t2_store_nostall", first_stall, 1'b0);
        do_access(32'h48, 1'b1, 1'b0, '0);
        chk("t2_readback", last_data, 32'h12345678);

        // Conflict on a dirty line: writeback then allocate.
        do_access(32'h448, 1'b1, 1'b0, '0);
        chk("t3_wb_addr", last_wb_addr, 32'h40);
        chk("t3_wb_word2", last_wb_data[95:64], 32'h12345678);
        chk("t3_fetch_addr", last_fetch_addr, 32'h440);
        do_access(32'h448, 1'b1, 1'b0, '0);
        chk("t3_hit_after", first_stall, 1'b0);

        // Store miss to a clean line merges after refill; eviction carries the merged word.
        do_access(32'h64, 1'b0, 1'b1, 32'hCAFEF00D);
        chk("t4_store_miss", first_stall, 1'b1);
        do_access(32'h464, 1'b1, 1'b0, '0);
        chk("t4_wb_addr", last_wb_addr, 32'h60);
        chk("t4_wb_word1", last_wb_data[63:32], 32'hCAFEF00D);

        // Reset in the middle of an allocate.
        addr_i    = 32'h840;
        MemRead_i = 1'b1;
        @(negedge clk);
        chk("t5_miss_stall", stall_o, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5_alloc_en", mem_enable_o, 1'b1);
        chk("t5_alloc_addr", mem_addr_o, 32'h840);
        #2;
        rst_i = 1'b0;
        #1;
        chk("t5_rst_en", mem_enable_o, 1'b0);
        chk("t5_rst_stall", stall_o, 1'b0);
        chk("t5_rst_addr", mem_addr_o, 32'h0);
        chk("t5_rst_data", data_o, 32'h0);
        model_reset();
        mem_ack_i = 1'b1;
        @(posedge clk);
        #1;
        mem_ack_i = 1'b0;
        MemRead_i = 1'b0;
        #3;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        do_access(32'h448, 1'b1, 1'b0, '0);
        chk("t5_miss_after_rst", first_stall, 1'b1);

        // Spurious ack in IDLE, then both request lines high is a store.
        idle_cycle(1'b1);
        do_access(32'h44C, 1'b1, 1'b1, 32'hA5A5A5A5);
        chk("t6_both_nostall", first_stall, 1'b0);
        do_access(32'h44C, 1'b1, 1'b0, '0);
        chk("t6_both_stored", last_data, 32'hA5A5A5A5);

        // Randomized traffic over a few indices and tags to force conflicts.
        for (int n = 0; n < 200; n++) begin
            op   = $urandom_range(0, 9);
            tsel = $urandom_range(0, 3);
            ra   = $urandom();
            ra[9:5]   = (tsel == 3) ? ra[9:5] : 5'($urandom_range(0, 3));
            ra[31:10] = 22'($urandom_range(0, 3) * 5);
            if (op < 2) idle_cycle($urandom_range(0, 1) == 1);
            else if (op < 6) do_access(ra, 1'b1, 1'b0, '0);
            else if (op < 9) do_access(ra, 1'b0, 1'b1, $urandom());
            else do_access(ra, 1'b1, 1'b1, $urandom());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
